// File: rtl/rv32i_pkg.sv
// rv32i_pkg
//   Shared definitions for the multi-cycle RV32I core: base opcodes,
//   load/store funct3 encodings, the FSM state type and a helper that
//   flags misaligned data accesses.
//   No ports (package).
package rv32i_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    // Halfwords need bit0 clear, words need both low bits clear.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lo);
        case (f3[1:0])
            2'b01:   return lo[0];
            2'b10:   return lo != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/rv32i_multicycle_core_lsu_lane.sv
// lsu_lane
//   Combinational byte-lane logic for the load/store unit.
//   funct3     : load/store width and signedness
//   addr_lo    : byte offset within the word
//   store_data : rs2 value to be stored
//   load_word  : full memory word returned for a load
//   be, wdata  : store byte enables and lane-replicated write data
//   load_value : selected lane, sign- or zero-extended to 32 bits
module lsu_lane
    import rv32i_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] load_word,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_value
);

    logic [31:0] shifted;

    always_comb begin
        be    = 4'hF;
        wdata = store_data;
        case (funct3[1:0])
            2'b00: begin
                be    = 4'b0001 << addr_lo;
                wdata = {4{store_data[7:0]}};
            end
            2'b01: begin
                be    = 4'b0011 << addr_lo;
                wdata = {2{store_data[15:0]}};
            end
            default: ;
        endcase
    end

    // Bring the addressed lane down to bit 0 before extending it.
    always_comb begin
        shifted    = load_word >> {addr_lo, 3'b000};
        load_value = load_word;
        case (funct3)
            F3_B:    load_value = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    load_value = {{16{shifted[15]}}, shifted[15:0]};
            F3_BU:   load_value = {24'b0, shifted[7:0]};
            F3_HU:   load_value = {16'b0, shifted[15:0]};
            default: load_value = load_word;
        endcase
    end

endmodule

// File: rtl/rv32i_multicycle_core.sv
// rv32i_multicycle_core
//   Multi-cycle RV32I core with one shared instruction/data memory port.
//   clk, reset_n        : clock and asynchronous active-low reset
//   mem_req/we/addr/be/wdata, mem_rdata, mem_ack : req/ack memory port
//   io_in               : reserved, ignored
//   halted              : core has stopped (trap, illegal or misalignment)
//   instret             : retired-instruction counter
//   debug_output        : low DEBUG_W bits of pc
module rv32i_multicycle_core
    import rv32i_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR     = 32'h0000_0000,
    parameter int          DEBUG_W          = 8,
    parameter int          HALT_ON_MISALIGN = 1
) (
    input  logic               clk,
    input  logic               reset_n,
    output logic               mem_req,
    output logic               mem_we,
    output logic [31:0]        mem_addr,
    output logic [3:0]         mem_be,
    output logic [31:0]        mem_wdata,
    input  logic [31:0]        mem_rdata,
    input  logic               mem_ack,
    input  logic [3:0]         io_in,
    output logic               halted,
    output logic [31:0]        instret,
    output logic [DEBUG_W-1:0] debug_output
);

    localparam bit HALT_MIS = (HALT_ON_MISALIGN != 0);

    state_t      state;
    logic [31:0] pc, ir, a_r, b_r, imm_r, aluout, mdr;
    logic [31:0] regs [32];

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm, alu_b, alu_res, eff_addr, wb_data, next_pc;
    logic        is_mem_op, is_store, access_mis, writes_rd, taken;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata, load_value;
    logic [1:0]  lane_lo;
    logic        unused_io;

    assign opcode       = ir[6:0];
    assign funct3       = ir[14:12];
    assign rd           = ir[11:7];
    assign rs1          = ir[19:15];
    assign rs2          = ir[24:20];
    assign is_store     = (opcode == OP_STORE);
    assign is_mem_op    = is_store || (opcode == OP_LOAD);
    assign debug_output = pc[DEBUG_W-1:0];
    assign unused_io    = ^io_in;

    // Immediate formats selected by opcode class.
    always_comb begin
        case (opcode)
            OP_LUI, OP_AUIPC: imm = {ir[31:12], 12'b0};
            OP_JAL:    imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
            OP_BRANCH: imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            OP_STORE:  imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
            default:   imm = {{20{ir[31]}}, ir[31:20]};
        endcase
    end

    // ALU: branches compare A against B and yield 1 for taken; everything
    // that is not a register op or branch uses the immediate as operand B.
    always_comb begin
        alu_b   = (opcode == OP_REG || opcode == OP_BRANCH) ? b_r : imm_r;
        alu_res = a_r + alu_b;
        taken   = 1'b0;
        if (opcode == OP_REG || opcode == OP_IMM) begin
            case (funct3)
                3'b000: alu_res = (opcode == OP_REG && ir[30]) ? a_r - alu_b : a_r + alu_b;
                3'b001: alu_res = a_r << alu_b[4:0];
                3'b010: alu_res = {31'b0, $signed(a_r) < $signed(alu_b)};
                3'b011: alu_res = {31'b0, a_r < alu_b};
                3'b100: alu_res = a_r ^ alu_b;
                3'b101: alu_res = ir[30] ? 32'($signed(a_r) >>> alu_b[4:0]) : a_r >> alu_b[4:0];
                3'b110: alu_res = a_r | alu_b;
                default: alu_res = a_r & alu_b;
            endcase
        end else if (opcode == OP_BRANCH) begin
            case (funct3)
                3'b000:  taken = (a_r == b_r);
                3'b001:  taken = (a_r != b_r);
                3'b100:  taken = ($signed(a_r) < $signed(b_r));
                3'b101:  taken = ($signed(a_r) >= $signed(b_r));
                3'b110:  taken = (a_r < b_r);
                3'b111:  taken = (a_r >= b_r);
                default: taken = 1'b0;
            endcase
            alu_res = {31'b0, taken};
        end
    end

    // With halting disabled a misaligned data address is silently aligned.
    always_comb begin
        access_mis = is_misaligned(funct3, alu_res[1:0]);
        eff_addr   = alu_res;
        if (!HALT_MIS && access_mis)
            eff_addr[1:0] = (funct3[1:0] == 2'b01) ? {alu_res[1], 1'b0} : 2'b00;
    end

    // During EXEC the lane logic builds the store; afterwards it extracts the load.
    assign lane_lo = (state == S_EXEC) ? eff_addr[1:0] : aluout[1:0];

    lsu_lane u_lsu_lane (
        .funct3     (funct3),
        .addr_lo    (lane_lo),
        .store_data (b_r),
        .load_word  (mdr),
        .be         (lane_be),
        .wdata      (lane_wdata),
        .load_value (load_value)
    );

    always_comb begin
        writes_rd = 1'b1;
        case (opcode)
            OP_LUI:         wb_data = imm_r;
            OP_AUIPC:       wb_data = pc + imm_r;
            OP_JAL, OP_JALR: wb_data = pc + 32'd4;
            OP_LOAD:        wb_data = load_value;
            default:        wb_data = aluout;
        endcase
        if (opcode == OP_STORE || opcode == OP_BRANCH) writes_rd = 1'b0;
        case (opcode)
            OP_JALR:   next_pc = (a_r + imm_r) & ~32'd1;
            OP_JAL:    next_pc = pc + imm_r;
            OP_BRANCH: next_pc = aluout[0] ? pc + imm_r : pc + 32'd4;
            default:   next_pc = pc + 32'd4;
        endcase
    end

    // Register file; x0 stays zero because writes to it are dropped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
        end else if (state == S_WB && writes_rd && rd != 5'd0) begin
            regs[rd] <= wb_data;
        end
    end

    // Main sequencer. Memory outputs are registered and raised on entry to
    // FETCH/MEM so a zero-wait ack completes the access in a single cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_FETCH;  pc <= RESET_VECTOR;
            mem_req <= 1'b0;   mem_we <= 1'b0;  mem_addr <= 32'd0;
            mem_be <= 4'd0;    mem_wdata <= 32'd0;
            halted <= 1'b0;    instret <= 32'd0;
            ir <= 32'd0; a_r <= 32'd0; b_r <= 32'd0; imm_r <= 32'd0;
            aluout <= 32'd0; mdr <= 32'd0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (!mem_req) begin
                        mem_req  <= 1'b1;  mem_we <= 1'b0;
                        mem_addr <= {pc[31:2], 2'b00};  mem_be <= 4'hF;
                    end else if (mem_ack) begin
                        ir      <= mem_rdata;
                        mem_req <= 1'b0;
                        state   <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    a_r   <= regs[rs1];
                    b_r   <= regs[rs2];
                    imm_r <= imm;
                    case (opcode)
                        OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
                        OP_LOAD, OP_STORE, OP_IMM, OP_REG: state <= S_EXEC;
                        default: begin state <= S_HALT; halted <= 1'b1; end
                    endcase
                end
                S_EXEC: begin
                    if (!is_mem_op) begin
                        aluout <= alu_res;
                        state  <= S_WB;
                    end else if (HALT_MIS && access_mis) begin
                        state  <= S_HALT;
                        halted <= 1'b1;
                    end else begin
                        aluout    <= eff_addr;
                        mem_req   <= 1'b1;
                        mem_we    <= is_store;
                        mem_addr  <= {eff_addr[31:2], 2'b00};
                        mem_be    <= is_store ? lane_be : 4'hF;
                        mem_wdata <= is_store ? lane_wdata : 32'd0;
                        state     <= S_MEM;
                    end
                end
                S_MEM: begin
                    if (mem_ack) begin
                        mdr     <= mem_rdata;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        state   <= S_WB;
                    end
                end
                S_WB: begin
                    if (HALT_MIS && next_pc[1:0] != 2'b00) begin
                        state  <= S_HALT;
                        halted <= 1'b1;
                    end else begin
                        pc       <= {next_pc[31:2], 2'b00};
                        instret  <= instret + 32'd1;
                        mem_req  <= 1'b1;  mem_we <= 1'b0;
                        mem_addr <= {next_pc[31:2], 2'b00};  mem_be <= 4'hF;
                        state    <= S_FETCH;
                    end
                end
                default: begin
                    mem_req <= 1'b0;
                    halted  <= 1'b1;
                end
            endcase
        end
    end

endmodule
